// File: rtl/inmux_arb_4_1.sv
// Round-robin burst arbiter feeding the 512-bit input data mux (k1/k13/k15).
// Define INMUX_ARB_STATS_EN to add per-source accepted-beat counters.
module inmux_arb_4_1 #(
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t_k1_valid,
    input  logic       t_k13_valid,
    input  logic       t_k15_valid,
    input  logic       t_k1_last,
    input  logic       t_k13_last,
    input  logic       t_k15_last,
    output logic       t_k1_ready,
    output logic       t_k13_ready,
    output logic       t_k15_ready,
    output logic [3:0] t_c_dat,
    output logic       i_inmux_valid,
    output logic       i_inmux_last,
    input  logic       i_inmux_ready
`ifdef INMUX_ARB_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_k1_beats,
    output logic [31:0] stat_k13_beats,
    output logic [31:0] stat_k15_beats
`endif
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_BEATS - 1);

    state_t           state, state_nxt;
    logic [1:0]       gnt, gnt_nxt;
    logic [1:0]       rr, rr_nxt;
    logic [1:0]       pick, idx;
    logic             found;
    logic [3:0]       dat_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       vld, lst, rdy;
    logic             g_vld, g_lst, lock, xfer;

    // Source index 0/1/2 = k1/k13/k15; rotation order k1 -> k13 -> k15.
    function automatic logic [1:0] succ(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [3:0] code(input logic [1:0] s);
        logic [3:0] c;
        unique case (s)
            2'd0:    c = 4'd1;
            2'd1:    c = 4'd5;
            2'd2:    c = 4'd7;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    assign vld = {t_k15_valid, t_k13_valid, t_k1_valid};
    assign lst = {t_k15_last, t_k13_last, t_k1_last};

    always_comb begin
        g_vld = 1'b0;
        g_lst = 1'b0;
        unique case (gnt)
            2'd0: begin
                g_vld = vld[0];
                g_lst = lst[0];
            end
            2'd1: begin
                g_vld = vld[1];
                g_lst = lst[1];
            end
            2'd2: begin
                g_vld = vld[2];
                g_lst = lst[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        pick  = rr;
        found = 1'b0;
        idx   = rr;
        for (int i = 0; i < 3; i++) begin
            if (!found && vld[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = succ(idx);
        end
    end

    // Outputs are suppressed during reset so a dropped grant never leaks a ready.
    assign lock = (state == LOCK) && !reset;
    assign xfer = (state == LOCK) && g_vld && i_inmux_ready;

    always_comb begin
        rdy = 3'b000;
        if (lock && i_inmux_ready) begin
            unique case (gnt)
                2'd0:    rdy = 3'b001;
                2'd1:    rdy = 3'b010;
                2'd2:    rdy = 3'b100;
                default: rdy = 3'b000;
            endcase
        end
    end

    assign t_k1_ready    = rdy[0];
    assign t_k13_ready   = rdy[1];
    assign t_k15_ready   = rdy[2];
    assign i_inmux_valid = lock && g_vld;
    assign i_inmux_last  = lock && g_lst;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        dat_nxt   = t_c_dat;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (|vld) begin
                    state_nxt = LOCK;
                    gnt_nxt   = pick;
                    dat_nxt   = code(pick);
                    cnt_nxt   = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (g_lst || cnt == LIM) begin
                        state_nxt = IDLE;
                        dat_nxt   = 4'd0;
                        rr_nxt    = succ(gnt);
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= 2'd0;
            rr      <= 2'd0;
            t_c_dat <= 4'd0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            rr      <= rr_nxt;
            t_c_dat <= dat_nxt;
            cnt     <= cnt_nxt;
        end
    end

`ifdef INMUX_ARB_STATS_EN
    logic [2:0] acc;
    assign acc = rdy & vld;

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_k1_beats  <= '0;
            stat_k13_beats <= '0;
            stat_k15_beats <= '0;
        end else begin
            stat_k1_beats  <= stat_k1_beats + 32'(acc[0]);
            stat_k13_beats <= stat_k13_beats + 32'(acc[1]);
            stat_k15_beats <= stat_k15_beats + 32'(acc[2]);
        end
    end
`endif

endmodule

// File: tb/tb_inmux_arb_4_1.sv
// Directed bench for inmux_arb_4_1: source models plus code/beat scoreboards.
// Stats checks are built in when INMUX_ARB_STATS_EN is defined.
module tb_inmux_arb_4_1;

    localparam int MB = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] v = '0;
    logic [2:0] l = '0;
    logic [2:0] r;
    logic [3:0] t_c_dat;
    logic       iv, il;
    logic       ir = 1'b1;
`ifdef INMUX_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] s1, s13, s15;
`endif

    int         passes = 0;
    int         total = 0;
    int         rem[3];
    int         pos[3];
    int         blen[3];
    bit         tog = 1'b0;
    logic [3:0] codeq[$];
    logic [4:0] beatq[$];

    always #5 clk = ~clk;

    inmux_arb_4_1 #(.MAX_BEATS(MB), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .t_k1_valid    (v[0]),
        .t_k13_valid   (v[1]),
        .t_k15_valid   (v[2]),
        .t_k1_last     (l[0]),
        .t_k13_last    (l[1]),
        .t_k15_last    (l[2]),
        .t_k1_ready    (r[0]),
        .t_k13_ready   (r[1]),
        .t_k15_ready   (r[2]),
        .t_c_dat       (t_c_dat),
        .i_inmux_valid (iv),
        .i_inmux_last  (il),
        .i_inmux_ready (ir)
`ifdef INMUX_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_k1_beats (s1),
        .stat_k13_beats(s13),
        .stat_k15_beats(s15)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic load(input int s, input int n, input int b);
        rem[s]  = n;
        blen[s] = b;
        pos[s]  = 0;
    endtask

    task automatic drive();
        for (int s = 0; s < 3; s++) begin
            v[s] = rem[s] > 0;
            l[s] = (rem[s] > 0) && (pos[s] == blen[s] - 1);
        end
    endtask

    task automatic pc(input logic [3:0] c, input int n);
        repeat (n) codeq.push_back(c);
    endtask

    task automatic pb(input logic [3:0] c, input int n, input bit endlast);
        for (int i = 0; i < n; i++)
            beatq.push_back({c, endlast && (i == n - 1)});
    endtask

    task automatic tick();
        logic [3:0] ec;
        logic [4:0] eb;
        logic [2:0] acc;
        int         gs;
        @(negedge clk);
        if (codeq.size() > 0) begin
            ec = codeq.pop_front();
            chk("t_c_dat", t_c_dat, ec);
            gs = (ec == 4'd1) ? 0 : (ec == 4'd5) ? 1 : (ec == 4'd7) ? 2 : -1;
            for (int s = 0; s < 3; s++)
                chk($sformatf("ready%0d", s), r[s], (gs == s) && ir && !reset);
            chk("valid", iv, (gs >= 0) && !reset && v[(gs >= 0) ? gs : 0]);
        end
        if (iv && ir) begin
            if (beatq.size() == 0) begin
                total++;
                $error("FAIL beat_extra: got beat %0h want none", {t_c_dat, il});
            end else begin
                eb = beatq.pop_front();
                chk("beat", {t_c_dat, il}, eb);
            end
        end
        acc = r & v;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (acc[s]) begin
                rem[s]--;
                pos[s] = (pos[s] == blen[s] - 1) ? 0 : pos[s] + 1;
            end
        end
        if (tog) ir = ~ir;
        drive();
    endtask

    task automatic run();
        while (codeq.size() > 0) tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 3; s++) load(s, 0, 1);
        drive();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_dat", t_c_dat, 4'd0);
        chk("rst_rdy", r, 3'b000);
        chk("rst_valid", iv, 1'b0);
        chk("rst_last", il, 1'b0);
        @(posedge clk);
        #1;

        // three sources, 3-beat bursts, k1 comes back for a second burst
        load(0, 6, 3);
        load(1, 3, 3);
        load(2, 3, 3);
        drive();
        pc(0, 1); pc(1, 3); pc(0, 1); pc(5, 3); pc(0, 1);
        pc(7, 3); pc(0, 1); pc(1, 3); pc(0, 1);
        pb(1, 3, 1); pb(5, 3, 1); pb(7, 3, 1); pb(1, 3, 1);
        run();

        // rr now at k13 with k13 idle: k15 must win over k1
        load(0, 2, 2);
        load(2, 2, 2);
        drive();
        pc(0, 1); pc(7, 2); pc(0, 1); pc(1, 2); pc(0, 1);
        pb(7, 2, 1); pb(1, 2, 1);
        run();

        // 100-beat k13 burst split by the beat limit
        load(1, 100, 100);
        drive();
        pc(0, 1); pc(5, MB); pc(0, 1); pc(5, 100 - MB); pc(0, 1);
        pb(5, 100, 1);
        run();

        // k15 with toggling downstream ready
        load(2, 4, 4);
        ir  = 1'b1;
        tog = 1'b1;
        drive();
        pc(0, 1); pc(7, 8); pc(0, 1);
        pb(7, 4, 1);
        run();
        tog = 1'b0;
        ir  = 1'b1;

        // reset during beat 2 of a k1 burst
        load(0, 4, 4);
        drive();
        pc(0, 1); pc(1, 1);
        pb(1, 1, 0);
        run();
        reset = 1'b1;
        pc(1, 1);
        tick();
        reset = 1'b0;
        load(1, 1, 1);
        drive();
        pc(0, 1); pc(1, 3); pc(0, 1); pc(5, 1); pc(0, 1);
        pb(1, 3, 1); pb(5, 1, 1);
        run();

`ifdef INMUX_ARB_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_k1_clr0", s1, 32'd0);
        load(0, 6, 6);
        drive();
        pc(0, 1); pc(1, 6); pc(0, 1);
        pb(1, 6, 1);
        repeat (6) tick();
        chk("stat_k1_5", s1, 32'd5);
        chk("stat_k13_0", s13, 32'd0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_k1_clr", s1, 32'd0);
        run();
`endif

        chk("beatq_left", beatq.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
